// File: rtl/tour_reverser.sv
// Tour order register file with in-place 2-opt segment reversal.
// A swap request is accepted from IDLE. A legal request with res=1 reverses
// positions i+1..j, exchanging one element pair per cycle. A legal request with
// res=0 finishes at once. An illegal request only raises err.
// Optional build macro TOUR_PERM_CHECK_EN adds the sticky perm_err output. It is
// set when the sum of all tour entries no longer matches a reference sum that
// is updated on init writes.
module tour_reverser #(
  parameter int unsigned N    = 16,
  parameter int unsigned IW   = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_en,
  input  logic [IW-1:0]   init_addr,
  input  logic [IW-1:0]   init_data,
  input  logic [IW-1:0]   rd_addr,
  output logic [IW-1:0]   rd_data,
  input  logic            swap_valid,
  output logic            swap_ready,
  input  logic [IW-1:0]   swap_i,
  input  logic [IW-1:0]   swap_j,
  input  logic            swap_res,
  output logic            busy,
  output logic            done,
  output logic            err,
`ifdef TOUR_PERM_CHECK_EN
  output logic            perm_err,
`endif
  output logic [CNTW-1:0] swap_count
);

  typedef enum logic [1:0] {StIdle, StSwap, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [IW-1:0]   r_tour [N];
  // Pointers carry one extra bit so that i+1 == N cannot wrap to 0.
  logic [IW:0]     r_lo, r_hi;
  logic            r_err;
  logic [CNTW-1:0] r_count;

  logic            w_accept, w_legal, w_init_wr, w_lo_lt_hi;
  logic [IW:0]     w_i_ext, w_j_ext;

  assign w_i_ext    = {1'b0, swap_i};
  assign w_j_ext    = {1'b0, swap_j};
  assign w_accept   = swap_valid && swap_ready;
  assign w_legal    = (w_i_ext < w_j_ext) && (w_j_ext < (IW+1)'(N));
  // Init writes lose to a request that is accepted on the same edge.
  assign w_init_wr  = (r_state == StIdle) && !w_accept && init_en;
  assign w_lo_lt_hi = r_lo < r_hi;

  assign rd_data    = r_tour[rd_addr];
  assign swap_ready = (r_state == StIdle);
  assign busy       = (r_state == StSwap) || (r_state == StDone);
  assign done       = (r_state == StDone);
  assign err        = r_err;
  assign swap_count = r_count;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_d;
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: if (w_accept && w_legal) w_state_d = swap_res ? StSwap : StDone;
      StSwap: if (!w_lo_lt_hi) w_state_d = StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Tour contents, reversal pointers, error pulse and applied-swap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) r_tour[k] <= IW'(k);
      r_lo    <= '0;
      r_hi    <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_err <= w_accept && !w_legal;
      case (r_state)
        StIdle: begin
          if (w_accept && w_legal && swap_res) begin
            r_lo <= w_i_ext + (IW+1)'(1);
            r_hi <= w_j_ext;
          end else if (w_init_wr) begin
            r_tour[init_addr] <= init_data;
          end
        end
        StSwap: begin
          if (w_lo_lt_hi) begin
            r_tour[r_lo[IW-1:0]] <= r_tour[r_hi[IW-1:0]];
            r_tour[r_hi[IW-1:0]] <= r_tour[r_lo[IW-1:0]];
            r_lo <= r_lo + (IW+1)'(1);
            r_hi <= r_hi - (IW+1)'(1);
          end else begin
            r_count <= r_count + CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TOUR_PERM_CHECK_EN
  localparam int unsigned SW = IW + $clog2(N) + 1;

  logic [SW-1:0] r_ref_sum, w_sum;
  logic          r_perm_err;

  // Sum of all entries; a reversal must leave it unchanged.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N; k++) w_sum = w_sum + SW'(r_tour[k]);
  end

  // Reference sum tracks init writes; a mismatch in DONE latches perm_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ref_sum  <= SW'(N * (N - 1) / 2);
      r_perm_err <= 1'b0;
    end else begin
      if (w_init_wr) r_ref_sum <= r_ref_sum - SW'(r_tour[init_addr]) + SW'(init_data);
      if ((r_state == StDone) && (w_sum != r_ref_sum)) r_perm_err <= 1'b1;
    end
  end

  assign perm_err = r_perm_err;
`endif

endmodule

// File: doc/tour_reverser.md
Name: tour_reverser

Overview:
- Consumer of the 2-opt swap checker's verdict. Owns the TSP tour order register file (N city indices).
- On an accepted swap request with res=1, reverses tour segment positions i+1..j in place, one element pair per cycle.
- Provides a combinational read port so the point sequencer can fetch tour[k] when building the next x1..y6 set for the checker.

Parameters:
N, 16, number of cities / tour positions (>=4)
IW, 4, index width, equals clog2(N)
CNTW, 16, width of applied-swap counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
init_en  in  1  write tour[init_addr] <= init_data; honoured only in IDLE
init_addr  in  IW  tour position to write
init_data  in  IW  city index to write
rd_addr  in  IW  tour position to read
rd_data  out  IW  tour[rd_addr], combinational
swap_valid  in  1  swap request present
swap_ready  out  1  high only in IDLE
swap_i  in  IW  first cut position i
swap_j  in  IW  second cut position j
swap_res  in  1  checker verdict: 1 = apply reversal, 0 = discard
busy  out  1  high in SWAP and DONE
done  out  1  one-cycle pulse, request finished (applied or discarded)
err  out  1  one-cycle pulse, request rejected as illegal
swap_count  out  CNTW  number of reversals applied since reset, wraps at 2^CNTW

Behaviour:
- Reset (rst=0, async): tour[k]=k for all k; state IDLE; done=0, err=0, busy=0, swap_count=0, lo/hi pointers=0. Reset mid-reversal abandons it; tour returns to identity.
- Handshake: request accepted on rising edge where swap_valid && swap_ready. Inputs sampled only at acceptance.
- Legality at acceptance: illegal if i>=j or j>=N. Illegal -> stay IDLE, err=1 next cycle, no tour change, no done, swap_count unchanged.
- Legal, swap_res=0 -> go DONE; done=1 for one cycle; back to IDLE. No tour change.
- Legal, swap_res=1 -> lo<=i+1, hi<=j; state SWAP.
- SWAP: if lo<hi, tour[lo]<=tour[hi], tour[hi]<=tour[lo], lo<=lo+1, hi<=hi-1. If lo>=hi, go DONE; swap_count<=swap_count+1.
- DONE: done=1 for one cycle, then IDLE.
- Latency, accept edge to done high: floor((j-i)/2)+2 cycles for res=1; 1 cycle for res=0. j=i+1 gives zero exchange cycles, so latency is 2.
- init_en while busy or on the accept edge: ignored.
- rd_data while SWAP reflects partially reversed contents; readers wait for done.
- Pointer arithmetic in IW+1 bits so i+1=N cannot wrap. No wrap-around reversal across position N-1 -> 0.
- swap_valid held high across done: next request accepted the first cycle back in IDLE.

Optional Feature:
TOUR_PERM_CHECK_EN
- Defined: add output perm_err (1 bit, sticky, reset 0).
- Module keeps a reference sum of all tour entries, updated on every init write (subtract old entry, add new).
- In DONE, compare the combinational sum of all entries against the reference; mismatch sets perm_err until reset.
- Undefined: port and logic absent; reversal behaviour unchanged.

Test Plan:
- Reset, read all positions -> rd_data=k for k=0..15; swap_ready=1, swap_count=0.
- Identity tour, i=2, j=7, res=1 -> two exchange cycles; done 4 cycles after accept; tour[3..7]=7,6,5,4,3; other positions unchanged; swap_count=1.
- i=5, j=6, res=1 -> done 2 cycles after accept; tour unchanged (single element); swap_count increments.
- i=0, j=15, res=0 -> done 1 cycle after accept; tour unchanged; swap_count unchanged.
- i=9, j=9 and i=3, j=16 (with IW widened) -> err pulse each time, no done, tour unchanged, swap_ready stays 1.
- Start i=0, j=15, res=1; drop rst after 3 cycles -> tour is identity, busy=0, swap_count=0. Also check init_en during SWAP is ignored.
